// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    DONE    = 2'd3
  } boot_state_e;

  localparam int unsigned DEFAULT_ADDR_W = 10;
  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam logic [31:0] HALT_INSN_EBREAK = 32'h00100073;

endpackage

// File: rtl/imem_boot_loader.sv
// Streams a program into instruction memory, then releases the core and
// watches its fetch stream for the halt instruction or budget exhaustion.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned         ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned         DATA_W     = DEFAULT_DATA_W,
  parameter logic [DATA_W-1:0]   HALT_INSN  = DATA_W'(HALT_INSN_EBREAK),
  parameter int unsigned         MAX_CYCLES = 10000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst_n,
  input  logic [DATA_W-1:0] core_insn,
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       cycle_count,
  output logic              load_overflow,
  output logic              run_complete,
  output logic              timeout
);

  localparam logic [ADDR_W-1:0] PTR_MAX    = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   WORDS_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [31:0]       LAST_CYCLE = 32'(MAX_CYCLES - 1);

  boot_state_e       state;
  boot_state_e       state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic              hs;
  logic              ptr_full;
  logic              halt_seen;
  logic              budget_end;

  // Next-state decode; halt takes priority over budget exhaustion.
  always_comb begin
    state_next = state;
    hs         = s_valid & s_ready;
    ptr_full   = (wr_ptr == PTR_MAX);
    halt_seen  = (core_insn == HALT_INSN);
    budget_end = (cycle_count == LAST_CYCLE);
    unique case (state)
      LOAD:    if (hs && (s_last || ptr_full)) state_next = RELEASE;
      RELEASE: state_next = RUN;
      RUN:     if (halt_seen || budget_end) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOAD;
      s_ready       <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
      core_rst_n    <= 1'b0;
      wr_ptr        <= '0;
      words_loaded  <= '0;
      cycle_count   <= '0;
      load_overflow <= 1'b0;
      run_complete  <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state   <= state_next;
      imem_we <= 1'b0;
      unique case (state)
        LOAD: begin
          s_ready <= (state_next == LOAD);
          if (hs) begin
            imem_we    <= 1'b1;
            imem_addr  <= wr_ptr;
            imem_wdata <= s_data;
            wr_ptr     <= wr_ptr + ADDR_W'(1);
            if (words_loaded != WORDS_MAX) words_loaded <= words_loaded + (ADDR_W+1)'(1);
            if (ptr_full && !s_last) load_overflow <= 1'b1;
          end
        end
        RELEASE: begin
          s_ready    <= 1'b0;
          core_rst_n <= 1'b1;
        end
        RUN: begin
          if (halt_seen)       run_complete <= 1'b1;
          else if (budget_end) timeout      <= 1'b1;
          else                 cycle_count  <= cycle_count + 32'd1;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule
